// File: rtl/vx_dispatch_arb_pkg.sv
// Shared constants for the dispatch arbiter slice.
//   PERF_CTR_BITS : width of performance counters
//   idx_width()   : index width for a requester count (never below 1)
package vx_dispatch_arb_pkg;

  localparam int PERF_CTR_BITS = 44;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_dispatch_arb_if.sv
// Dispatch bus between issue slices, arbiter and execute unit.
//   req_valid/req_data/req_eop/req_ready : per-slice request side
//   out_valid/out_data/out_eop/out_idx/out_ready : execute-unit side
// modport master : issue slices + execute unit (drive requests, accept output)
// modport slave  : the arbiter
interface vx_dispatch_arb_if
  import vx_dispatch_arb_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 64
);
  localparam int IDXW = idx_width(NUM_REQS);

  logic [NUM_REQS-1:0]       req_valid;
  logic [NUM_REQS*DATAW-1:0] req_data;
  logic [NUM_REQS-1:0]       req_eop;
  logic [NUM_REQS-1:0]       req_ready;
  logic                      out_valid;
  logic [DATAW-1:0]          out_data;
  logic                      out_eop;
  logic [IDXW-1:0]           out_idx;
  logic                      out_ready;

  modport master (
    output req_valid, req_data, req_eop, out_ready,
    input  req_ready, out_valid, out_data, out_eop, out_idx
  );

  modport slave (
    input  req_valid, req_data, req_eop, out_ready,
    output req_ready, out_valid, out_data, out_eop, out_idx
  );
endinterface

// File: rtl/vx_dispatch_arb_rr_select.sv
// Rotating find-first: first set bit of valid_i searching upward from ptr_i,
// wrapping modulo N. Purely combinational.
//   valid_i       : request vector
//   ptr_i         : search start position (< N)
//   grant_valid_o : some request found
//   grant_idx_o   : index of the found request
module vx_dispatch_arb_rr_select #(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    valid_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic            grant_valid_o,
  output logic [IDXW-1:0] grant_idx_o
);
  int unsigned idx;

  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    idx           = 0;
    for (int unsigned k = 0; k < int'(N); k++) begin
      idx = 32'(ptr_i) + k;
      if (idx >= int'(N)) idx = idx - int'(N);
      if (!grant_valid_o && valid_i[IDXW'(idx)]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = IDXW'(idx);
      end
    end
  end
endmodule

// File: rtl/vx_dispatch_arb.sv
// Round-robin dispatch arbiter: NUM_REQS issue slices share one registered
// execute-unit dispatch port. Multi-beat packets hold the grant until eop.
//   clk         : clock, rising edge
//   reset       : asynchronous, active-low
//   bus         : dispatch interface (slave modport)
//   perf_stalls : cycles with a pending request but no transfer (wraps)
module vx_dispatch_arb
  import vx_dispatch_arb_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  vx_dispatch_arb_if.slave         bus,
  output logic [PERF_CTR_BITS-1:0] perf_stalls
);
  localparam int IDXW = idx_width(NUM_REQS);

  logic                     out_valid_q;
  logic [DATAW-1:0]         out_data_q;
  logic                     out_eop_q;
  logic [IDXW-1:0]          out_idx_q;
  logic [IDXW-1:0]          rr_ptr_q, rr_ptr_d;
  logic                     lock_q;
  logic [IDXW-1:0]          lock_idx_q;
  logic [PERF_CTR_BITS-1:0] perf_q;

  logic                     rr_valid;
  logic [IDXW-1:0]          rr_idx;
  logic                     grant_valid;
  logic [IDXW-1:0]          grant_idx;
  logic                     slot_free;
  logic                     fire;
  logic                     sel_eop;
  logic [DATAW-1:0]         sel_data;

  vx_dispatch_arb_rr_select #(
    .N    (NUM_REQS),
    .IDXW (IDXW)
  ) u_rr_select (
    .valid_i       (bus.req_valid),
    .ptr_i         (rr_ptr_q),
    .grant_valid_o (rr_valid),
    .grant_idx_o   (rr_idx)
  );

  // A locked packet owns the port; others wait even if the owner idles.
  always_comb begin
    grant_valid = rr_valid;
    grant_idx   = rr_idx;
    if (lock_q) begin
      grant_valid = bus.req_valid[lock_idx_q];
      grant_idx   = lock_idx_q;
    end
  end

  assign slot_free = !out_valid_q || bus.out_ready;
  assign fire      = grant_valid && slot_free && reset;
  assign sel_eop   = bus.req_eop[grant_idx];

  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < int'(NUM_REQS); k++) begin
      if (grant_idx == IDXW'(k)) sel_data = bus.req_data[k*DATAW +: DATAW];
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (fire) bus.req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (fire && sel_eop) begin
      rr_ptr_d = (grant_idx == IDXW'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_eop_q   <= 1'b0;
      out_idx_q   <= '0;
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      perf_q      <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      // Load and drain in the same cycle keeps out_valid high: no bubble.
      if (fire) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_data;
        out_eop_q   <= sel_eop;
        out_idx_q   <= grant_idx;
        lock_q      <= !sel_eop;
        lock_idx_q  <= grant_idx;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if ((|bus.req_valid) && !fire) perf_q <= perf_q + 1'b1;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.out_idx   = out_idx_q;
  assign perf_stalls   = perf_q;
endmodule
